// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Purpose:
//   Shares one single-clock block SRAM (one write port, one read port,
//   1-cycle read latency) between NUM_REQ requesters. One access (read or
//   write) is granted per cycle using round-robin priority. The granted
//   payload drives the SRAM ports combinationally. Read data is routed back
//   to the requester that issued the read, one cycle after its handshake.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous, active-high reset
//   req_valid_i  per-requester request valid
//   req_ready_o  per-requester grant (one-hot, or zero when nobody is valid)
//   req_we_i     per-requester write enable (1 = write, 0 = read)
//   req_addr_i   packed byte addresses, slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata_i  packed write data, sliced the same way
//   req_wstrb_i  packed byte strobes, sliced the same way
//   rsp_valid_o  per-requester read response valid
//   rsp_rdata_o  read data, shared by all requesters
//   wvalid_o     SRAM write enable
//   awaddr_o     SRAM write address
//   wdata_o      SRAM write data
//   wstrb_o      SRAM write strobes
//   araddr_o     SRAM read address
//   rdata_i      SRAM read data, valid one cycle after araddr_o
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    input  logic [NUM_REQ*STRB_WIDTH-1:0] req_wstrb_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic                          wvalid_o,
    output logic [ADDR_WIDTH-1:0]         awaddr_o,
    output logic [DATA_WIDTH-1:0]         wdata_o,
    output logic [STRB_WIDTH-1:0]         wstrb_o,
    output logic [ADDR_WIDTH-1:0]         araddr_o,
    input  logic [DATA_WIDTH-1:0]         rdata_i
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Refuse to elaborate with parameters the datapath cannot support.
    generate
        if (NUM_REQ < 2 || DATA_WIDTH == 0 || (DATA_WIDTH % 8) != 0) begin : g_bad_params
            $fatal(1, "sram_arbiter: NUM_REQ must be >= 2 and DATA_WIDTH a non-zero multiple of 8");
        end
    endgenerate

    logic [PTR_W-1:0]   prio_q;
    logic [PTR_W-1:0]   prio_next;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               grant_we;
    logic [NUM_REQ-1:0] rsp_sel_q;
    int                 cand;

    // Round-robin pick: scan from the priority pointer upward, wrapping,
    // and take the first valid requester. The grant depends only on valids
    // and the pointer, never on ready.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(prio_q) + k) % NUM_REQ;
            if (!grant_valid && req_valid_i[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
    end

    // Turn the chosen index into a one-hot ready and route the granted
    // payload onto the SRAM ports. The read address simply follows the
    // granted slice; it only matters when the grant is a read. A write is
    // suppressed while reset is asserted so nothing lands in the SRAM then.
    always_comb begin
        req_ready_o = '0;
        if (grant_valid) begin
            req_ready_o[grant_idx] = 1'b1;
        end
        grant_we = req_we_i[grant_idx];
        wvalid_o = grant_valid && grant_we && !rst_i;
        awaddr_o = req_addr_i[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        araddr_o = req_addr_i[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_o  = req_wdata_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        wstrb_o  = req_wstrb_i[int'(grant_idx)*STRB_WIDTH +: STRB_WIDTH];
    end

    // The requester after the winner gets first pick next cycle.
    always_comb begin
        if (int'(grant_idx) == NUM_REQ - 1) begin
            prio_next = '0;
        end else begin
            prio_next = grant_idx + PTR_W'(1);
        end
    end

    // Pointer and response-select registers. A granted read remembers its
    // requester for exactly one cycle, matching the SRAM read latency;
    // writes and idle cycles clear it. Reset drops any in-flight response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q    <= '0;
            rsp_sel_q <= '0;
        end else begin
            if (grant_valid) begin
                prio_q <= prio_next;
            end
            if (grant_valid && !grant_we) begin
                rsp_sel_q <= req_ready_o;
            end else begin
                rsp_sel_q <= '0;
            end
        end
    end

    assign rsp_valid_o = rsp_sel_q;
    assign rsp_rdata_o = rdata_i;

endmodule
